// File: rtl/mips32_pkg.sv
// mips32_pkg
// Shared types for the mips32 boot loader.
//   ldr_state_e : loader sequencing states
//   SEL_IMEM/SEL_DMEM : values of the load-stream memory select bit
package mips32_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DUMP,
        DONE
    } ldr_state_e;

    localparam logic SEL_IMEM = 1'b0;
    localparam logic SEL_DMEM = 1'b1;

endpackage

// File: rtl/ldr_skid_buf.sv
// ldr_skid_buf
// One-entry valid/ready holding register for the dump read path. Once a word
// is captured it stays on the output until the consumer takes it.
// Ports:
//   clk_x, rst_x           clock, synchronous active-high reset
//   in_valid/in_data/in_last  word arriving from the memory read
//   in_ready               buffer can take a word this cycle
//   out_valid/out_data/out_last/out_ready  downstream stream
module ldr_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk_x,
    input  logic              rst_x,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    logic              full;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    // Room exists when empty, or when the held word leaves this cycle.
    assign in_ready  = !full || out_ready;
    assign out_valid = full;
    assign out_data  = data_q;
    assign out_last  = full && last_q;

    always_ff @(posedge clk_x) begin
        if (rst_x) begin
            full   <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            full   <= 1'b1;
            data_q <= in_data;
            last_q <= in_last;
        end else if (out_ready) begin
            full   <= 1'b0;
        end
    end

endmodule

// File: rtl/mips32_boot_loader.sv
// mips32_boot_loader
// Loads imem/dmem from a valid/ready stream with the core held in reset,
// runs the core under an optional watchdog until HLT, lets the pipeline
// drain, then streams a window of dmem back out.
// Ports:
//   clk_x, rst_x                 clock, synchronous active-high reset
//   start                        begin a session (IDLE/DONE only)
//   in_*                         load stream (sel 0=imem, 1=dmem)
//   tmo_cycles                   run-cycle limit, 0 disables the watchdog
//   dump_base, dump_count        dump window, captured at start
//   core_rst, core_halted        core control / HLT retired indication
//   imem_*                       imem write port
//   dmem_own, dmem_*             dmem port ownership and loader-side port
//   out_*                        dump stream
//   busy, done, timeout, cycles_run  status
module mips32_boot_loader
    import mips32_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024,
    parameter int TMO_W      = 16,
    parameter int DRAIN_CYC  = 5
) (
    input  logic              clk_x,
    input  logic              rst_x,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [TMO_W-1:0]  tmo_cycles,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_count,
    output logic              core_rst,
    input  logic              core_halted,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              dmem_own,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [TMO_W-1:0]  cycles_run
);

    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [ADDR_W:0] IMEM_LIM = (ADDR_W+1)'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] DMEM_LIM = (ADDR_W+1)'(DMEM_DEPTH);

    ldr_state_e        state, next_state;
    logic [DRN_W-1:0]  drain_cnt;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   issued;
    logic              rd_pending;
    logic              rd_last;
    logic              load_fire;
    logic              tmo_hit;
    logic              rd_issue;
    logic              skid_ready;
    logic              core_live;

    assign tmo_hit   = (tmo_cycles != '0) && (cycles_run == tmo_cycles);
    assign load_fire = in_ready && in_valid;
    assign core_live = (state == RUN) || (state == DRAIN);

    // A read is only launched when its data is guaranteed a slot in the
    // buffer on the following cycle, and only one read is ever in flight.
    assign rd_issue = (state == DUMP) && (issued < count_q) && !rd_pending && skid_ready;

    // Next-state and combinational port control.
    always_comb begin
        next_state = state;
        in_ready   = (state == LOAD);
        core_rst   = !core_live;
        dmem_own   = !core_live;
        busy       = state inside {LOAD, RUN, DRAIN, DUMP};
        done       = (state == DONE);
        imem_addr  = in_addr;
        imem_wdata = in_data;
        dmem_wdata = in_data;
        imem_we    = load_fire && (in_sel == SEL_IMEM) && ({1'b0, in_addr} < IMEM_LIM);
        dmem_we    = load_fire && (in_sel == SEL_DMEM) && ({1'b0, in_addr} < DMEM_LIM);
        dmem_addr  = (state == DUMP) ? (base_q + issued[ADDR_W-1:0]) : in_addr;
        case (state)
            IDLE:  if (start) next_state = LOAD;
            LOAD:  if (in_valid && in_last) next_state = RUN;
            RUN:   if (core_halted || tmo_hit) next_state = DRAIN;
            DRAIN: if (drain_cnt == DRN_W'(DRAIN_CYC - 1))
                       next_state = (count_q == '0) ? DONE : DUMP;
            DUMP:  if (out_valid && out_ready && out_last) next_state = DONE;
            DONE:  if (start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    // State register, counters and captured session settings.
    always_ff @(posedge clk_x) begin
        if (rst_x) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            base_q     <= '0;
            count_q    <= '0;
            issued     <= '0;
            rd_pending <= 1'b0;
            rd_last    <= 1'b0;
            cycles_run <= '0;
            timeout    <= 1'b0;
        end else begin
            state <= next_state;
            if (((state == IDLE) || (state == DONE)) && start) begin
                base_q     <= dump_base;
                count_q    <= dump_count;
                cycles_run <= '0;
                timeout    <= 1'b0;
            end
            // The cycle that ends RUN is not counted, so a watchdog expiry
            // leaves cycles_run equal to the programmed limit.
            if ((state == RUN) && (next_state == RUN) && (cycles_run != '1))
                cycles_run <= cycles_run + 1'b1;
            // Halt takes priority over an expiry landing on the same cycle.
            if ((state == RUN) && !core_halted && tmo_hit)
                timeout <= 1'b1;
            drain_cnt  <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
            issued     <= (state != DUMP) ? '0 : (rd_issue ? issued + 1'b1 : issued);
            rd_pending <= rd_issue;
            rd_last    <= rd_issue && (issued == count_q - 1'b1);
        end
    end

    ldr_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk_x     (clk_x),
        .rst_x     (rst_x),
        .in_valid  (rd_pending),
        .in_ready  (skid_ready),
        .in_data   (dmem_rdata),
        .in_last   (rd_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_mips32_boot_loader.sv
// tb_mips32_boot_loader
// Directed bench for the boot loader. Provides imem/dmem models and a tiny
// single-cycle core stub, drives load streams, and scoreboards dump beats.
module tb_mips32_boot_loader;

    localparam int IMEM_D = 1000;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_MUL  = 6'd5;
    localparam logic [5:0] OP_LW   = 6'd8;
    localparam logic [5:0] OP_SW   = 6'd9;
    localparam logic [5:0] OP_ADDI = 6'd10;
    localparam logic [5:0] OP_HLT  = 6'h3f;

    logic        clk = 1'b0;
    logic        rst_x, start, in_valid, in_sel, in_last;
    logic [9:0]  in_addr, dump_base;
    logic [31:0] in_data;
    logic [15:0] tmo_cycles;
    logic [10:0] dump_count;
    logic        core_rst, core_halted, in_ready;
    logic        imem_we, dmem_own, dmem_we;
    logic [9:0]  imem_addr, dmem_addr;
    logic [31:0] imem_wdata, dmem_wdata, dmem_rdata, out_data;
    logic        out_valid, out_ready, out_last;
    logic        busy, done, timeout;
    logic [15:0] cycles_run;

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;
    int ready_mode = 0;
    logic [32:0] exp_q[$];
    logic [31:0] exp_dmem [0:1023];

    logic [31:0] imem_arr [0:1023];
    logic [31:0] dmem_arr [0:1023];
    logic [31:0] regs     [0:31];
    logic [9:0]  pc;
    logic        halted;

    always #5 clk = ~clk;

    mips32_boot_loader #(.IMEM_DEPTH(IMEM_D)) dut (
        .clk_x(clk), .rst_x(rst_x), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_addr(in_addr), .in_data(in_data), .in_last(in_last),
        .tmo_cycles(tmo_cycles), .dump_base(dump_base), .dump_count(dump_count),
        .core_rst(core_rst), .core_halted(core_halted),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_own(dmem_own), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .timeout(timeout),
        .cycles_run(cycles_run)
    );

    // Core stub: one instruction per cycle; fields {op,rs,rt,rd/imm}.
    logic [31:0] cur;
    logic [5:0]  c_op;
    logic [4:0]  c_rs, c_rt, c_rd;
    logic [31:0] c_ea, c_imm;
    assign cur         = imem_arr[pc];
    assign c_op        = cur[31:26];
    assign c_rs        = cur[25:21];
    assign c_rt        = cur[20:16];
    assign c_rd        = cur[15:11];
    assign c_imm       = {{16{cur[15]}}, cur[15:0]};
    assign c_ea        = regs[c_rs] + c_imm;
    assign core_halted = halted;

    // Memories and core in one process so each array has a single writer.
    always @(posedge clk) begin
        if (imem_we) imem_arr[imem_addr] <= imem_wdata;
        if (dmem_own) begin
            if (dmem_we) dmem_arr[dmem_addr] <= dmem_wdata;
            dmem_rdata <= dmem_arr[dmem_addr];
        end
        if (core_rst) begin
            pc     <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            case (c_op)
                OP_ADD:  regs[c_rd] <= regs[c_rs] + regs[c_rt];
                OP_MUL:  regs[c_rd] <= regs[c_rs] * regs[c_rt];
                OP_ADDI: regs[c_rt] <= c_ea;
                OP_LW:   regs[c_rt] <= dmem_arr[c_ea[9:0]];
                OP_SW:   dmem_arr[c_ea[9:0]] <= regs[c_rt];
                OP_HLT:  halted <= 1'b1;
                default: ;
            endcase
            pc <= pc + 10'd1;
        end
    end

    function automatic logic [31:0] r_type(input logic [5:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 11'b0};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rt,
                                           input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One load beat; the write strobes are combinational on the accept cycle.
    task automatic apply_stimulus(input logic sel, input logic [9:0] addr,
                                  input logic [31:0] data, input logic last);
        in_valid = 1'b1;
        in_sel   = sel;
        in_addr  = addr;
        in_data  = data;
        in_last  = last;
        #1;
        check_output("load_ready", 32'(in_ready), 32'd1);
        check_output("imem_we", 32'(imem_we), 32'(!sel && (int'(addr) < IMEM_D)));
        check_output("dmem_we", 32'(dmem_we), 32'(sel));
        if (sel) exp_dmem[addr] = data;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic start_session(input logic [9:0] base, input logic [10:0] cnt,
                                 input logic [15:0] tmo);
        dump_base  = base;
        dump_count = cnt;
        tmo_cycles = tmo;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        check_output("start_busy", 32'(busy), 32'd1);
        check_output("start_core_rst", 32'(core_rst), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check_output(tag, 32'(done), 32'd1);
    endtask

    // Consumer back-pressure pattern.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = !out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Dump monitor: scoreboard pops on handshake, and held beats must not move.
    initial begin
        logic        hold_pend;
        logic [31:0] hold_data;
        logic        hold_last;
        logic [32:0] e;
        hold_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_x) begin
                hold_pend = 1'b0;
            end else begin
                if (out_valid) valid_seen++;
                if (hold_pend) begin
                    check_output("hold_valid", 32'(out_valid), 32'd1);
                    check_output("hold_data", out_data, hold_data);
                    check_output("hold_last", 32'(out_last), 32'(hold_last));
                end
                if (out_valid && out_ready) begin
                    check_output("sb_occupancy", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_output("dump_data", out_data, e[31:0]);
                        check_output("dump_last", 32'(out_last), 32'(e[32]));
                    end
                end
                hold_pend = out_valid && !out_ready;
                hold_data = out_data;
                hold_last = out_last;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            imem_arr[i] = '0;
            dmem_arr[i] = '0;
            exp_dmem[i] = '0;
        end
        for (int i = 0; i < 32; i++) regs[i] = '0;
        rst_x = 1'b1; start = 1'b0; in_valid = 1'b0; in_sel = 1'b0;
        in_addr = '0; in_data = '0; in_last = 1'b0;
        tmo_cycles = '0; dump_base = '0; dump_count = '0;
        repeat (3) tick();

        $display("[TB] reset state");
        check_output("rst_core_rst", 32'(core_rst), 32'd1);
        check_output("rst_dmem_own", 32'(dmem_own), 32'd1);
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_last", 32'(out_last), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_timeout", 32'(timeout), 32'd0);
        check_output("rst_cycles", 32'(cycles_run), 32'd0);
        rst_x = 1'b0;
        tick();

        $display("[TB] test 1: program with HLT");
        start_session(10'd3, 11'd1, 16'd0);
        exp_q.push_back({1'b1, 32'h18});
        apply_stimulus(1'b1, 10'd1, 32'd5, 1'b0);
        apply_stimulus(1'b1, 10'd2, 32'd7, 1'b0);
        apply_stimulus(1'b0, 10'd0, i_type(OP_LW, 5'd1, 5'd0, 16'd1), 1'b0);
        apply_stimulus(1'b0, 10'd1, i_type(OP_LW, 5'd2, 5'd0, 16'd2), 1'b0);
        apply_stimulus(1'b0, 10'd2, r_type(OP_ADD, 5'd3, 5'd1, 5'd2), 1'b0);
        apply_stimulus(1'b0, 10'd3, i_type(OP_ADDI, 5'd5, 5'd0, 16'd2), 1'b0);
        apply_stimulus(1'b0, 10'd4, r_type(OP_MUL, 5'd4, 5'd3, 5'd5), 1'b0);
        apply_stimulus(1'b0, 10'd5, i_type(OP_SW, 5'd4, 5'd0, 16'd3), 1'b0);
        apply_stimulus(1'b0, 10'd6, {OP_HLT, 26'd0}, 1'b1);
        check_output("t1_run_core_rst", 32'(core_rst), 32'd0);
        check_output("t1_run_dmem_own", 32'(dmem_own), 32'd0);
        wait_done("t1_done", 300);
        check_output("t1_timeout", 32'(timeout), 32'd0);
        check_output("t1_done_core_rst", 32'(core_rst), 32'd1);
        check_output("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] test 2: watchdog");
        start_session(10'd20, 11'd2, 16'd50);
        apply_stimulus(1'b1, 10'd20, 32'hA5A5_0001, 1'b0);
        apply_stimulus(1'b1, 10'd21, 32'h5A5A_0002, 1'b0);
        for (int i = 0; i < 8; i++)
            apply_stimulus(1'b0, 10'(i), 32'd0, (i == 7));
        exp_q.push_back({1'b0, exp_dmem[20]});
        exp_q.push_back({1'b1, exp_dmem[21]});
        wait_done("t2_done", 400);
        check_output("t2_timeout", 32'(timeout), 32'd1);
        check_output("t2_cycles", 32'(cycles_run), 32'd50);
        check_output("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] test 3: toggling out_ready");
        ready_mode = 1;
        start_session(10'd10, 11'd4, 16'd0);
        check_output("t3_timeout_clr", 32'(timeout), 32'd0);
        check_output("t3_cycles_clr", 32'(cycles_run), 32'd0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 10'(10 + i), $urandom, 1'b0);
        apply_stimulus(1'b0, 10'd0, {OP_HLT, 26'd0}, 1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), exp_dmem[10 + i]});
        wait_done("t3_done", 400);
        check_output("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] test 4: address wrap");
        ready_mode = 2;
        start_session(10'd1022, 11'd4, 16'd0);
        apply_stimulus(1'b1, 10'd1022, 32'h1111_1022, 1'b0);
        apply_stimulus(1'b1, 10'd1023, 32'h2222_1023, 1'b0);
        apply_stimulus(1'b1, 10'd0, 32'h3333_0000, 1'b0);
        apply_stimulus(1'b1, 10'd1, 32'h4444_0001, 1'b0);
        apply_stimulus(1'b0, 10'd0, {OP_HLT, 26'd0}, 1'b1);
        exp_q.push_back({1'b0, exp_dmem[1022]});
        exp_q.push_back({1'b0, exp_dmem[1023]});
        exp_q.push_back({1'b0, exp_dmem[0]});
        exp_q.push_back({1'b1, exp_dmem[1]});
        wait_done("t4_done", 400);
        check_output("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        ready_mode = 0;

        $display("[TB] test 5: reset during RUN, start during LOAD");
        start_session(10'd0, 11'd1, 16'd0);
        apply_stimulus(1'b0, 10'd0, 32'd0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("t5_start_ignored", 32'(in_ready), 32'd1);
        apply_stimulus(1'b0, 10'd1, 32'd0, 1'b1);
        repeat (3) tick();
        check_output("t5_running", 32'(core_rst), 32'd0);
        rst_x = 1'b1;
        tick();
        check_output("t5_core_rst", 32'(core_rst), 32'd1);
        check_output("t5_busy", 32'(busy), 32'd0);
        check_output("t5_in_ready", 32'(in_ready), 32'd0);
        check_output("t5_cycles", 32'(cycles_run), 32'd0);
        check_output("t5_dmem_own", 32'(dmem_own), 32'd1);
        rst_x = 1'b0;
        tick();

        $display("[TB] test 6: empty dump, out-of-range imem write");
        valid_seen = 0;
        start_session(10'd5, 11'd0, 16'd0);
        apply_stimulus(1'b0, 10'd1000, 32'hDEAD_BEEF, 1'b0);
        apply_stimulus(1'b0, 10'd0, {OP_HLT, 26'd0}, 1'b1);
        wait_done("t6_done", 300);
        check_output("t6_no_valid", 32'(valid_seen), 32'd0);
        check_output("t6_timeout", 32'(timeout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
